ob_cmd_ingress: RTL
===================

OB_CMD_INGRESS -- requirements
Module: ob_cmd_ingress

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 Parameter CNT_W, default 32, meaning width of the statistics counters.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_vld  in  1  upstream command valid.
REQ-006 in_cmd  in  ob_pkg::cmd_t  upstream command (opcode, uid, quantity, price, uid1).
REQ-007 in_rdy  out  1  ingress can take a command this cycle.
REQ-008 cmd_vld_r  out  1  registered command valid to order book.
REQ-009 cmd_r  out  ob_pkg::cmd_t  registered command to order book.
REQ-010 cmd_full_r  in  1  order-book command queue full (registered by the order book).
REQ-011 halt  in  1  stop issuing to order book; buffering continues.
REQ-012 stat_accepted_r  out  CNT_W  commands accepted from upstream.
REQ-013 stat_issued_r  out  CNT_W  commands issued to order book.
REQ-014 stat_dropped_r  out  CNT_W  commands dropped for illegal opcode.
REQ-015 occupancy_r  out  clog2(DEPTH)+1  FIFO entries held.

Function
REQ-016 Upstream transfer SHALL occur when in_vld & in_rdy; in_rdy SHALL be combinational from FIFO state only (not from in_vld).
REQ-017 in_rdy SHALL be 1 when occupancy_r < DEPTH, or when occupancy_r == DEPTH and a pop occurs the same cycle.
REQ-018 A transferred command whose opcode fails ob_pkg::opcode_is_legal SHALL not be written, SHALL increment stat_dropped_r, and SHALL still count in stat_accepted_r.
REQ-019 Legal transferred commands SHALL be written to the FIFO in arrival order; no reordering.
REQ-020 Issue condition in cycle t: occupancy_r != 0 & !cmd_full_r & !halt & state == RUN.
REQ-021 On issue in cycle t the head entry SHALL be popped, cmd_r loaded with it, and cmd_vld_r = 1 in cycle t+1 for exactly one cycle.
REQ-022 cmd_vld_r SHALL be 0 in any cycle following a non-issue cycle; cmd_r SHALL hold its last value when cmd_vld_r = 0.
REQ-023 Minimum latency: legal command written in cycle t (empty FIFO, no stall) SHALL appear on cmd_vld_r in cycle t+2.
REQ-024 Throughput: one command per cycle sustained while cmd_full_r = 0 and halt = 0.
REQ-025 Simultaneous push and pop SHALL leave occupancy_r unchanged; full FIFO with pop SHALL accept the push.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH with one extra wrap bit for full/empty distinction.
REQ-027 State machine: RUN, HALTED; RUN->HALTED when halt = 1; HALTED->RUN when halt = 0; transition takes effect the cycle after halt changes; an issue decided in the cycle halt rises SHALL complete.
REQ-028 Counters SHALL increment by one per event and wrap at 2^CNT_W without saturation.
REQ-029 cmd_full_r rising in the same cycle as an issue SHALL not cancel that issue (order book absorbs one in-flight command).

Reset
REQ-030 On rst low: FIFO empty, occupancy_r = 0, cmd_vld_r = 0, cmd_r = 0, all stat counters = 0, state = RUN, asynchronously.
REQ-031 Reset mid-operation SHALL discard all buffered commands; no command SHALL be issued in the first cycle after rst deasserts.
REQ-032 in_rdy SHALL be 0 while rst is low.

Structure
REQ-033 ob_pkg SHALL own cmd_t, opcode_t and function opcode_is_legal; ingress state enum SHALL live in ob_pkg.
REQ-034 Storage SHALL be one sub-module ob_cmd_fifo (parameterised DEPTH, payload ob_pkg::cmd_t) instantiated once.

Verification
REQ-035 Single legal command uid=5 into empty FIFO at cycle 10 -> cmd_vld_r=1 at cycle 12 with cmd_r.uid=5, stat_issued_r=1.
REQ-036 cmd_full_r held 1, push 4 commands uid 1..4 (DEPTH 4) -> in_rdy=0, occupancy_r=4; release cmd_full_r -> uids 1,2,3,4 issued on 4 consecutive cycles.
REQ-037 Illegal opcode uid=9 between legal uid=8 and uid=10 -> only 8 then 10 issued, stat_dropped_r=1, stat_accepted_r=3.
REQ-038 halt=1 with 2 buffered commands -> no further cmd_vld_r beyond any in-flight one; halt=0 -> both issued in order.
REQ-039 Full FIFO with simultaneous push and pop for 20 cycles -> occupancy_r stays 4, 20 commands issued in order, no loss.
REQ-040 rst low for 1 cycle with 3 buffered -> occupancy_r=0, cmd_vld_r=0, counters 0; no issue until new push.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared order-book types: command payload, opcodes, ingress state.
// Also holds the opcode legality check used at the ingress boundary.
package ob_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_BUY    = 3'd1,
    OP_SELL   = 3'd2,
    OP_CANCEL = 3'd3,
    OP_MODIFY = 3'd4
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [15:0] uid;
    logic [15:0] quantity;
    logic [31:0] price;
    logic [15:0] uid1;
  } cmd_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HALTED  = 1'b1
  } ing_state_t;

  // NOP and the unassigned encodings never reach the book.
  function automatic logic opcode_is_legal(input opcode_t op);
    case (op)
      OP_BUY, OP_SELL, OP_CANCEL, OP_MODIFY: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ob_cmd_ingress_if.sv
// Upstream command handshake plus the registered command path to the order book.
interface ob_cmd_ingress_if;
  import ob_pkg::*;

  logic in_vld;
  cmd_t in_cmd;
  logic in_rdy;
  logic cmd_vld_r;
  cmd_t cmd_r;
  logic cmd_full_r;

  modport slave (
    input  in_vld, in_cmd, cmd_full_r,
    output in_rdy, cmd_vld_r, cmd_r
  );

  modport master (
    output in_vld, in_cmd, cmd_full_r,
    input  in_rdy, cmd_vld_r, cmd_r
  );

endinterface

// File: rtl/ob_cmd_fifo.sv
// Command FIFO with wrap-bit pointers; head is read combinationally.
module ob_cmd_fifo
  import ob_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  cmd_t                   i_data,
  input  logic                   i_pop,
  output cmd_t                   o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_occupancy
);

  localparam int AW = $clog2(DEPTH);

  cmd_t         r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Same index with differing wrap bits means every slot is occupied.
  assign o_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_occupancy = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ob_cmd_ingress.sv
// Order-book command ingress: filters illegal opcodes, buffers commands and
// issues them one per cycle as a registered stream, honouring halt/backpressure.
module ob_cmd_ingress
  import ob_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ob_cmd_ingress_if.slave        bus,
  input  logic                   halt,
  output logic [CNT_W-1:0]       stat_accepted_r,
  output logic [CNT_W-1:0]       stat_issued_r,
  output logic [CNT_W-1:0]       stat_dropped_r,
  output logic [$clog2(DEPTH):0] occupancy_r
);

  ing_state_t              r_state;
  logic                    r_cmd_vld;
  cmd_t                    r_cmd;
  logic [CNT_W-1:0]        r_accepted;
  logic [CNT_W-1:0]        r_issued;
  logic [CNT_W-1:0]        r_dropped;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_rdy;
  logic                    w_xfer;
  logic                    w_push;
  logic                    w_legal;
  cmd_t                    w_head;
  logic [$clog2(DEPTH):0]  w_occ;

  // Ready depends only on FIFO state and the pop decision, never on in_vld.
  assign w_pop   = !w_empty && !bus.cmd_full_r && !halt && (r_state == ST_RUN);
  assign w_rdy   = rst && (!w_full || w_pop);
  assign w_xfer  = bus.in_vld && w_rdy;
  assign w_legal = opcode_is_legal(bus.in_cmd.opcode);
  assign w_push  = w_xfer && w_legal;

  ob_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      (bus.in_cmd),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_occupancy (w_occ)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:    r_state <= halt ? ST_HALTED : ST_RUN;
        ST_HALTED: r_state <= halt ? ST_HALTED : ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  // The command register keeps its payload between issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_vld <= 1'b0;
      r_cmd     <= '0;
    end else begin
      r_cmd_vld <= w_pop;
      if (w_pop) begin
        r_cmd <= w_head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_accepted <= '0;
      r_issued   <= '0;
      r_dropped  <= '0;
    end else begin
      if (w_xfer) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end
      if (w_xfer && !w_legal) begin
        r_dropped <= r_dropped + CNT_W'(1);
      end
      if (w_pop) begin
        r_issued <= r_issued + CNT_W'(1);
      end
    end
  end

  assign bus.in_rdy      = w_rdy;
  assign bus.cmd_vld_r   = r_cmd_vld;
  assign bus.cmd_r       = r_cmd;
  assign stat_accepted_r = r_accepted;
  assign stat_issued_r   = r_issued;
  assign stat_dropped_r  = r_dropped;
  assign occupancy_r     = w_occ;

endmodule
